// File: rtl/ball_motion.sv
// Ball position and visibility controller: moves the ball once per frame,
// reflects it off the screen edges and sequences the hit / respawn blanking.
module ball_motion #(
   parameter int SCREEN_W       = 1024,
   parameter int SCREEN_H       = 768,
   parameter int BALL_SIZE      = 32,
   parameter int START_X        = 496,
   parameter int START_Y        = 368,
   parameter int HIT_FRAMES     = 30,
   parameter int RESPAWN_FRAMES = 60
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        launch,
   input  logic        hit,
   input  logic [3:0]  speed,
   output logic [10:0] x,
   output logic [9:0]  y,
   output logic [1:0]  ball_state,
   output logic        wall_bounce,
   output logic        moving
);

   localparam int TW    = 8;
   localparam int X_MAX = SCREEN_W - BALL_SIZE;
   localparam int Y_MAX = SCREEN_H - BALL_SIZE;

   typedef enum logic [1:0] {IDLE, MOVING, HIT, RESPAWN} state_t;

   state_t          state_r, state_s;
   logic [10:0]     x_r, x_s;
   logic [9:0]      y_r, y_s;
   logic            dir_x_neg_r, dir_x_neg_s;
   logic            dir_y_neg_r, dir_y_neg_s;
   logic [3:0]      spd_r, spd_s;
   logic [TW-1:0]   timer_r, timer_s;
   logic            vsync_d_r;
   logic [1:0]      ball_state_r, ball_state_s;
   logic            wall_bounce_r, wall_bounce_s;
   logic            moving_r, moving_s;
   logic            frame_s;
   logic            bounce_x_s, bounce_y_s;
   logic [11:0]     x_sum_s, y_sum_s;

   assign frame_s = vsync_d_r & ~vsync;

   // State, position and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         x_r           <= 11'(START_X);
         y_r           <= 10'(START_Y);
         dir_x_neg_r   <= 1'b0;
         dir_y_neg_r   <= 1'b0;
         spd_r         <= 4'd1;
         timer_r       <= '0;
         vsync_d_r     <= 1'b1;
         ball_state_r  <= 2'd0;
         wall_bounce_r <= 1'b0;
         moving_r      <= 1'b0;
      end else begin
         state_r       <= state_s;
         x_r           <= x_s;
         y_r           <= y_s;
         dir_x_neg_r   <= dir_x_neg_s;
         dir_y_neg_r   <= dir_y_neg_s;
         spd_r         <= spd_s;
         timer_r       <= timer_s;
         vsync_d_r     <= vsync;
         ball_state_r  <= ball_state_s;
         wall_bounce_r <= wall_bounce_s;
         moving_r      <= moving_s;
      end
   end

   // Next-state, motion and edge reflection
   always_comb begin
      state_s     = state_r;
      x_s         = x_r;
      y_s         = y_r;
      dir_x_neg_s = dir_x_neg_r;
      dir_y_neg_s = dir_y_neg_r;
      spd_s       = spd_r;
      timer_s     = timer_r;
      bounce_x_s  = 1'b0;
      bounce_y_s  = 1'b0;
      // 12-bit sums so x + spd can never wrap before the wall compare
      x_sum_s     = {1'b0, x_r} + {8'd0, spd_r};
      y_sum_s     = {2'b00, y_r} + {8'd0, spd_r};

      case (state_r)
         IDLE: begin
            if (launch) begin
               state_s = MOVING;
               spd_s   = (speed == 4'd0) ? 4'd1 : speed;
            end else begin
               state_s = IDLE;
            end
         end
         MOVING: begin
            if (hit) begin
               state_s = HIT;
               timer_s = TW'(HIT_FRAMES - 1);
            end else if (frame_s) begin
               if (!dir_x_neg_r) begin
                  if (x_sum_s >= 12'(X_MAX)) begin
                     x_s = 11'(X_MAX);
                     dir_x_neg_s = 1'b1;
                     bounce_x_s = 1'b1;
                  end else begin
                     x_s = x_sum_s[10:0];
                  end
               end else begin
                  if ({1'b0, x_r} <= {8'd0, spd_r}) begin
                     x_s = 11'd0;
                     dir_x_neg_s = 1'b0;
                     bounce_x_s = 1'b1;
                  end else begin
                     x_s = x_r - {7'd0, spd_r};
                  end
               end
               if (!dir_y_neg_r) begin
                  if (y_sum_s >= 12'(Y_MAX)) begin
                     y_s = 10'(Y_MAX);
                     dir_y_neg_s = 1'b1;
                     bounce_y_s = 1'b1;
                  end else begin
                     y_s = y_sum_s[9:0];
                  end
               end else begin
                  if ({2'b00, y_r} <= {8'd0, spd_r}) begin
                     y_s = 10'd0;
                     dir_y_neg_s = 1'b0;
                     bounce_y_s = 1'b1;
                  end else begin
                     y_s = y_r - {6'd0, spd_r};
                  end
               end
            end else begin
               state_s = MOVING;
            end
         end
         HIT: begin
            if (frame_s) begin
               if (timer_r == {TW{1'b0}}) begin
                  state_s     = RESPAWN;
                  x_s         = 11'(START_X);
                  y_s         = 10'(START_Y);
                  dir_x_neg_s = 1'b0;
                  dir_y_neg_s = 1'b0;
                  timer_s     = TW'(RESPAWN_FRAMES - 1);
               end else begin
                  timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
               end
            end else begin
               state_s = HIT;
            end
         end
         RESPAWN: begin
            if (frame_s) begin
               if (timer_r == {TW{1'b0}}) begin
                  state_s = IDLE;
               end else begin
                  timer_s = timer_r - {{(TW-1){1'b0}}, 1'b1};
               end
            end else begin
               state_s = RESPAWN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output encodings derived from the next state so they stay registered
   always_comb begin
      wall_bounce_s = bounce_x_s | bounce_y_s;
      moving_s      = (state_s == MOVING);
      case (state_s)
         HIT:     ball_state_s = 2'd1;
         RESPAWN: ball_state_s = 2'd2;
         default: ball_state_s = 2'd0;
      endcase
   end

   assign x           = x_r;
   assign y           = y_r;
   assign ball_state  = ball_state_r;
   assign wall_bounce = wall_bounce_r;
   assign moving      = moving_r;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: stimulus pushes expected outputs, a monitor
// pops and compares on every frame cycle and on explicit probe cycles.
module tb_ball_motion;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vsync = 1'b1;
   logic        launch = 1'b0;
   logic        hit = 1'b0;
   logic [3:0]  speed = 4'd0;
   logic [10:0] x;
   logic [9:0]  y;
   logic [1:0]  ball_state;
   logic        wall_bounce;
   logic        moving;

   typedef struct {
      logic        care;
      logic [10:0] x;
      logic [9:0]  y;
      logic [1:0]  bs;
      logic        wb;
      logic        mv;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   logic probe_s = 1'b0;
   logic vs_prev_r = 1'b1;
   logic tb_frame_r = 1'b0;

   ball_motion dut (
      .clk(clk), .reset(reset), .vsync(vsync), .launch(launch), .hit(hit),
      .speed(speed), .x(x), .y(y), .ball_state(ball_state),
      .wall_bounce(wall_bounce), .moving(moving)
   );

   always #5 clk = ~clk;

   // Bench-side frame detector: marks the cycle in which the DUT sees a frame
   always @(posedge clk) begin
      tb_frame_r <= vs_prev_r & ~vsync;
      vs_prev_r  <= vsync;
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
      end
   endtask

   // Monitor: pops one expectation per frame/probe cycle
   always @(negedge clk) begin
      if (tb_frame_r || probe_s) begin
         if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.care) begin
               chk("x", int'(x), int'(e.x));
               chk("y", int'(y), int'(e.y));
               chk("ball_state", int'(ball_state), int'(e.bs));
               chk("wall_bounce", int'(wall_bounce), int'(e.wb));
               chk("moving", int'(moving), int'(e.mv));
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic c, input int ex, input int ey, input int ebs,
                       input int ewb, input int emv);
      exp_t e;
      e.care = c;
      e.x    = 11'(ex);
      e.y    = 10'(ey);
      e.bs   = 2'(ebs);
      e.wb   = 1'(ewb);
      e.mv   = 1'(emv);
      sb_q.push_back(e);
   endtask

   task automatic frame(input int ex, input int ey, input int ebs, input int ewb,
                        input int emv, input logic hit_in);
      push(1'b1, ex, ey, ebs, ewb, emv);
      vsync = 1'b0;
      hit   = hit_in;
      cyc(1);
      hit = 1'b0;
      cyc(1);
      vsync = 1'b1;
      cyc(2);
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         push(1'b0, 0, 0, 0, 0, 0);
         vsync = 1'b0;
         cyc(2);
         vsync = 1'b1;
         cyc(2);
      end
   endtask

   task automatic probe(input int ex, input int ey, input int ebs, input int ewb,
                        input int emv);
      push(1'b1, ex, ey, ebs, ewb, emv);
      probe_s = 1'b1;
      cyc(1);
      probe_s = 1'b0;
   endtask

   task automatic do_launch(input logic [3:0] spd);
      launch = 1'b1;
      speed  = spd;
      cyc(1);
      launch = 1'b0;
      speed  = 4'd7;
   endtask

   initial begin
      #3;
      cyc(3);
      reset = 1'b0;
      probe(496, 368, 0, 0, 0);
      frame(496, 368, 0, 0, 0, 1'b0);
      frame(496, 368, 0, 0, 0, 1'b0);
      frame(496, 368, 0, 0, 0, 1'b0);

      // speed 4: reflections off bottom, right, top and left edges
      do_launch(4'd4);
      probe(496, 368, 0, 0, 1);
      frame(500, 372, 0, 0, 1, 1'b0);
      probe(500, 372, 0, 0, 1);
      run_frames(90);
      frame(864, 736, 0, 1, 1, 1'b0);
      frame(868, 732, 0, 0, 1, 1'b0);
      run_frames(30);
      frame(992, 608, 0, 1, 1, 1'b0);
      frame(988, 604, 0, 0, 1, 1'b0);
      run_frames(150);
      frame(384, 0, 0, 1, 1, 1'b0);
      frame(380, 4, 0, 0, 1, 1'b0);
      run_frames(94);
      frame(0, 384, 0, 1, 1, 1'b0);
      frame(4, 388, 0, 0, 1, 1'b0);

      // hit / respawn sequence with ignored launch and hit pulses
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      probe(4, 388, 1, 0, 0);
      do_launch(4'd9);
      frame(4, 388, 1, 0, 0, 1'b0);
      run_frames(27);
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      frame(4, 388, 1, 0, 0, 1'b0);
      frame(496, 368, 2, 0, 0, 1'b0);
      do_launch(4'd9);
      frame(496, 368, 2, 0, 0, 1'b1);
      run_frames(57);
      frame(496, 368, 2, 0, 0, 1'b0);
      frame(496, 368, 0, 0, 0, 1'b0);
      frame(496, 368, 0, 0, 0, 1'b0);

      // speed 15: bottom bounce, then right wall at 992 and back to 977
      do_launch(4'd15);
      run_frames(24);
      frame(871, 736, 0, 1, 1, 1'b0);
      run_frames(6);
      frame(976, 631, 0, 0, 1, 1'b0);
      frame(991, 616, 0, 0, 1, 1'b0);
      frame(992, 601, 0, 1, 1, 1'b0);
      probe(992, 601, 0, 0, 1);
      frame(977, 586, 0, 0, 1, 1'b0);

      // hit coincident with frame freezes position; reset mid-HIT
      frame(977, 586, 1, 0, 0, 1'b1);
      frame(977, 586, 1, 0, 0, 1'b0);
      reset = 1'b1;
      cyc(1);
      probe(496, 368, 0, 0, 0);
      reset = 1'b0;
      frame(496, 368, 0, 0, 0, 1'b0);

      // speed 0 launches at 1 pixel per frame
      do_launch(4'd0);
      frame(497, 369, 0, 0, 1, 1'b0);
      frame(498, 370, 0, 0, 1, 1'b0);

      cyc(2);
      chk("sb_leftover", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
